conv_window_mac: RTL
====================

CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

Interface
REQ-001 SHALL have parameter BITWIDTH, default 4, signed width of map, kernel and result elements.
REQ-002 SHALL have parameter KSIZE, default 5, kernel edge length; window = KSIZE x KSIZE, one row per beat.
REQ-003 SHALL have parameter FRAC_SHIFT, default 2, arithmetic right shift applied to the accumulated sum.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  row beat valid.
REQ-007 SHALL have port in_ready  output  1  block accepts a row beat.
REQ-008 SHALL have port in_map  input  KSIZE*BITWIDTH  one signed map row, element 0 in LSBs.
REQ-009 SHALL have port in_kernel  input  KSIZE*BITWIDTH  matching signed kernel row, element 0 in LSBs.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_value  output  BITWIDTH  signed, shifted, saturated window result.
REQ-013 SHALL have port out_sat  output  1  set with out_value when saturation clipped the result.

Function
REQ-014 SHALL use FSM states ACCUM and HOLD; reset state ACCUM.
REQ-015 In ACCUM in_ready SHALL be 1; a beat transfers on in_valid & in_ready.
REQ-016 Each transferred beat SHALL add the signed sum of KSIZE products in_map[i]*in_kernel[i] to the accumulator, width ACC_W = 2*BITWIDTH + clog2(KSIZE*KSIZE); no internal overflow.
REQ-017 A row counter 0..KSIZE-1 SHALL increment per beat; on the beat with counter KSIZE-1 the counter SHALL wrap to 0 and FSM SHALL go to HOLD next cycle.
REQ-018 Entering HOLD, out_value SHALL be (acc_final >>> FRAC_SHIFT) saturated to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1]; arithmetic shift rounds toward minus infinity.
REQ-019 Latency: out_valid SHALL rise the cycle after the last row beat transfers.
REQ-020 In HOLD in_ready SHALL be 0; out_value, out_sat and out_valid SHALL stay stable until out_valid & out_ready.
REQ-021 On output handshake SHALL clear accumulator, drop out_valid and return to ACCUM next cycle; first new beat accepted that cycle at earliest (throughput KSIZE+1 cycles per window with out_ready held 1).
REQ-022 in_valid low in ACCUM SHALL leave accumulator and counter unchanged (partial windows persist).

Reset
REQ-023 While rst_n=0 at a rising edge: state=ACCUM, counter=0, accumulator=0, out_valid=0, out_value=0, out_sat=0; in_ready reads 1 from the first post-reset cycle.
REQ-024 Reset mid-window or in HOLD SHALL discard partial sum and pending result without emitting it.

Configuration
REQ-025 With CONV_WINDOW_RELU_EN defined, a negative post-saturation result SHALL be output as 0 with out_sat unchanged; without it, signed results pass through unmodified.

Structure
REQ-026 A shared package SHALL hold the FSM state typedef and ACC_W width function.
REQ-027 Row product sum SHALL be a sub-module conv_row_dot (KSIZE signed products, combinational sum).

Verification
REQ-028 BITWIDTH=4, KSIZE=5, FRAC_SHIFT=2, all map=-1, kernel=1, 5 beats -> out_value=-7, out_sat=0, out_valid 1 cycle after beat 5.
REQ-029 Same stimulus with CONV_WINDOW_RELU_EN -> out_value=0, out_sat=0.
REQ-030 All map=-8, kernel=-8 -> sum 1600, >>>2 = 400 -> out_value=7, out_sat=1.
REQ-031 out_ready=0 for 10 cycles after result -> out_value stable, in_ready=0, in_valid beats ignored; result released on out_ready=1.
REQ-032 rst_n=0 after 3 beats, then full window of map=1, kernel=1 -> out_value=6 (25>>>2), no stale contribution.
REQ-033 Two back-to-back windows with in_valid toggling every other cycle, out_ready=1 -> two correct results, each computed from exactly 5 beats.

Source files
------------

// File: rtl/conv_window_mac_pkg.sv
// rtl/conv_window_mac_pkg.sv - shared FSM state type and accumulator width helper
package conv_window_mac_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // A full window holds ksize*ksize products of two bitwidth-wide signed
    // values, so this width holds the exact window sum without overflow.
    function automatic int acc_width(input int bitwidth, input int ksize);
        return 2 * bitwidth + $clog2(ksize * ksize);
    endfunction

endpackage

// File: rtl/conv_window_mac_row_dot.sv
// rtl/conv_window_mac_row_dot.sv - combinational signed dot product of one map row and one kernel row
// Ports:
//   map_i    : KSIZE packed signed map elements, element 0 in LSBs
//   kernel_i : KSIZE packed signed kernel elements, element 0 in LSBs
//   sum_o    : signed sum of the KSIZE products, sign-extended to OUT_W
module conv_row_dot #(
    parameter int BITWIDTH = 4,
    parameter int KSIZE    = 5,
    parameter int OUT_W    = 13
) (
    input  logic [KSIZE*BITWIDTH-1:0] map_i,
    input  logic [KSIZE*BITWIDTH-1:0] kernel_i,
    output logic signed [OUT_W-1:0]   sum_o
);

    logic signed [BITWIDTH-1:0]   m_el [KSIZE];
    logic signed [BITWIDTH-1:0]   k_el [KSIZE];
    logic signed [2*BITWIDTH-1:0] prod [KSIZE];

    for (genvar i = 0; i < KSIZE; i++) begin : g_prod
        assign m_el[i] = map_i[i*BITWIDTH +: BITWIDTH];
        assign k_el[i] = kernel_i[i*BITWIDTH +: BITWIDTH];
        // Sign-extend both operands to the full product width first.
        assign prod[i] = (2*BITWIDTH)'(m_el[i]) * (2*BITWIDTH)'(k_el[i]);
    end

    always_comb begin
        sum_o = '0;
        for (int i = 0; i < KSIZE; i++) begin
            sum_o = sum_o + OUT_W'(prod[i]);
        end
    end

endmodule

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - KSIZE x KSIZE window multiply-accumulate, one row per beat, shifted and saturated result
// Ports:
//   clk, rst_n          : clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   : row beat handshake; in_map/in_kernel carry one signed row each
//   out_valid/out_ready : result handshake; out_value is the shifted, saturated window sum
//   out_sat             : result was clipped by saturation
// Build option: CONV_WINDOW_RELU_EN clamps negative results to zero.
module conv_window_mac
    import conv_window_mac_pkg::*;
#(
    parameter int BITWIDTH   = 4,
    parameter int KSIZE      = 5,
    parameter int FRAC_SHIFT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [KSIZE*BITWIDTH-1:0] in_map,
    input  logic [KSIZE*BITWIDTH-1:0] in_kernel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BITWIDTH-1:0]       out_value,
    output logic                      out_sat
);

    localparam int ACC_W = acc_width(BITWIDTH, KSIZE);
    localparam int ROW_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (BITWIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

    state_t                   state_q;
    logic [ROW_W-1:0]         row_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  row_sum;
    logic signed [ACC_W-1:0]  acc_shift;
    logic [BITWIDTH-1:0]      out_value_q;
    logic [BITWIDTH-1:0]      res_d;
    logic                     out_valid_q;
    logic                     out_sat_q;
    logic                     sat_d;
    logic                     beat;
    logic                     last_beat;

    conv_row_dot #(
        .BITWIDTH (BITWIDTH),
        .KSIZE    (KSIZE),
        .OUT_W    (ACC_W)
    ) u_row_dot (
        .map_i    (in_map),
        .kernel_i (in_kernel),
        .sum_o    (row_sum)
    );

    assign in_ready  = (state_q == ST_ACCUM);
    assign beat      = in_valid & in_ready;
    assign last_beat = beat && (row_q == ROW_W'(KSIZE - 1));
    assign acc_d     = acc_q + row_sum;
    // Arithmetic shift of a signed value: rounds toward minus infinity.
    assign acc_shift = acc_d >>> FRAC_SHIFT;

    always_comb begin
        res_d = acc_shift[BITWIDTH-1:0];
        sat_d = 1'b0;
        if (acc_shift > SAT_MAX) begin
            res_d = SAT_MAX[BITWIDTH-1:0];
            sat_d = 1'b1;
        end else if (acc_shift < SAT_MIN) begin
            res_d = SAT_MIN[BITWIDTH-1:0];
            sat_d = 1'b1;
        end
`ifdef CONV_WINDOW_RELU_EN
        // Clamp after saturation; out_sat still reports any clipping.
        if (res_d[BITWIDTH-1]) begin
            res_d = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            row_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        if (last_beat) begin
                            row_q       <= '0;
                            state_q     <= ST_HOLD;
                            out_valid_q <= 1'b1;
                            out_value_q <= res_d;
                            out_sat_q   <= sat_d;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        acc_q       <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= ST_ACCUM;
                    end
                end
                default: state_q <= ST_ACCUM;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_sat   = out_sat_q;

endmodule
